// File: rtl/debug_loader.sv
// Byte-stream program loader: sync/length/data framing into core debug-load writes.
// Optional trailing XOR checksum is compiled in with `define LOADER_CHECKSUM_EN.
module debug_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        DEBUG_SIG,
  output logic [31:0] DEBUG_addr,
  output logic [31:0] DEBUG_instr,
  output logic        debug_we,
  output logic        core_nrst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StWrite,
`ifdef LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] words_q, words_d;
  logic [7:0]  len_lo_q, len_lo_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif
  logic        accept;

  assign accept = rx_valid & rx_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    words_d  = words_q;
    len_lo_d = len_lo_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      StIdle, StError: begin
        if (accept && rx_data == SyncByte) begin
          state_d = StLen0;
          addr_d  = BASE_ADDR;
          cnt_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      StLen0: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          words_d = {rx_data, len_lo_q};
          if ({16'h0000, rx_data, len_lo_q} > MAX_WORDS) begin
            state_d = StError;
          end else if ({rx_data, len_lo_q} == 16'h0000) begin
            state_d = StDone;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          instr_d[{cnt_q, 3'b000} +: 8] = rx_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + 32'd4;
        words_d = words_q - 16'd1;
        if (words_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StData;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? StDone : StError;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      addr_q   <= BASE_ADDR;
      instr_q  <= 32'h0000_0000;
      cnt_q    <= 2'd0;
      words_q  <= 16'h0000;
      len_lo_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      len_lo_q <= len_lo_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // Outputs decode straight from state so reset takes effect without waiting for a clock.
  assign rx_ready    = nrst & (state_q != StWrite) & (state_q != StDone);
  assign DEBUG_SIG   = (state_q != StIdle) & (state_q != StError);
  assign busy        = (state_q != StIdle) & (state_q != StError);
  assign core_nrst   = nrst & (state_q == StIdle);
  assign debug_we    = (state_q == StWrite);
  assign done        = (state_q == StDone);
  assign error       = (state_q == StError);
  assign DEBUG_addr  = addr_q;
  assign DEBUG_instr = instr_q;

endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader: cycle-exact vector table plus framing/reset/error sequences.
module tb_debug_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  // Flag packing: {rx_ready, DEBUG_SIG, debug_we, done, core_nrst, busy, error}
  localparam logic [6:0] FI = 7'b1000100;  // idle
  localparam logic [6:0] FA = 7'b1100010;  // receiving during a load
  localparam logic [6:0] FW = 7'b0110010;  // write strobe
  localparam logic [6:0] FD = 7'b0101010;  // done pulse

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        DEBUG_SIG;
  logic [31:0] DEBUG_addr;
  logic [31:0] DEBUG_instr;
  logic        debug_we;
  logic        core_nrst;
  logic        busy;
  logic        done;
  logic        error;

  debug_loader dut (
    .clk        (clk),
    .nrst       (nrst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .DEBUG_SIG  (DEBUG_SIG),
    .DEBUG_addr (DEBUG_addr),
    .DEBUG_instr(DEBUG_instr),
    .debug_we   (debug_we),
    .core_nrst  (core_nrst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [6:0]  flags;
    logic [31:0] addr;
    logic [31:0] instr;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] wbuf[4];
  int          checks = 0;
  int          failures = 0;
  int          we_cnt = 0;
  int          done_cnt = 0;
  int          ready_bad = 0;

  always @(negedge clk) begin
    if (debug_we) begin
      wa.push_back(DEBUG_addr);
      wd.push_back(DEBUG_instr);
      we_cnt++;
      if (rx_ready) ready_bad++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [6:0] f,
                     input logic [31:0] a, input logic [31:0] ins);
    vec_t e;
    e.v = v; e.d = d; e.flags = f; e.addr = a; e.instr = ins;
    vq.push_back(e);
  endtask

  // Offer a byte from a falling edge; returns once it will transfer on the next rising edge.
  task automatic send(input logic [7:0] b, input bit gap);
    int k;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    while (!rx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("send_timeout", 64'(k), 64'd0);
  endtask

  task automatic idle_rx();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("done_pulse", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic do_load(input int n, input bit gap);
    int         d0;
    logic [7:0] cs;
    logic [15:0] nn;
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    nn = 16'(n);
    cs = 8'h00;
    send(8'hA5, gap);
    send(nn[7:0], gap);
    send(nn[15:8], gap);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        send(wbuf[i][8*j +: 8], gap);
        cs = cs ^ wbuf[i][8*j +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send(cs, gap);
`endif
    idle_rx();
    wait_done(d0);
    chk("wr_count", 64'(wa.size()), 64'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk($sformatf("wr%0d_addr", i), 64'(wa[i]), 64'(BASE + 32'(4 * i)));
      chk($sformatf("wr%0d_data", i), 64'(wd[i]), 64'(wbuf[i]));
    end
    chk("core_nrst_after_load", 64'(core_nrst), 64'd1);
  endtask

  initial begin
    int d0;
    int w0;

    // Cycle-exact trace of the two-word reference stream (checksum 0x90).
    add(1'b1, 8'hA5, FI, 32'h0, 32'h0);
    add(1'b1, 8'h02, FA, 32'h0, 32'h0);
    add(1'b1, 8'h00, FA, 32'h0, 32'h0);
    add(1'b1, 8'h13, FA, 32'h0, 32'h0);
    add(1'b1, 8'h00, FA, 32'h0, 32'h13);
    add(1'b1, 8'h00, FA, 32'h0, 32'h13);
    add(1'b1, 8'h00, FA, 32'h0, 32'h13);
    add(1'b1, 8'h93, FW, 32'h0, 32'h13);
    add(1'b1, 8'h93, FA, 32'h4, 32'h13);
    add(1'b1, 8'h00, FA, 32'h4, 32'h93);
    add(1'b1, 8'h10, FA, 32'h4, 32'h93);
    add(1'b1, 8'h00, FA, 32'h4, 32'h0010_0093);
    add(1'b1, 8'h90, FW, 32'h4, 32'h0010_0093);
`ifdef LOADER_CHECKSUM_EN
    add(1'b1, 8'h90, FA, 32'h8, 32'h0010_0093);
`endif
    add(1'b0, 8'h00, FD, 32'h8, 32'h0010_0093);
    add(1'b0, 8'h00, FI, 32'h8, 32'h0010_0093);

    #2 nrst = 1'b0;
    #2;
    chk("rst_flags", 64'({rx_ready, DEBUG_SIG, debug_we, done, core_nrst, busy, error}), 64'd0);
    chk("rst_addr_instr", {DEBUG_addr, DEBUG_instr}, {BASE, 32'h0});
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rx_valid = vq[i].v;
      rx_data  = vq[i].d;
      chk($sformatf("vec%0d_flags", i),
          64'({rx_ready, DEBUG_SIG, debug_we, done, core_nrst, busy, error}), 64'(vq[i].flags));
      chk($sformatf("vec%0d_addr_instr", i), {DEBUG_addr, DEBUG_instr}, {vq[i].addr, vq[i].instr});
    end
    chk("vec_write_count", 64'(we_cnt), 64'd2);

    // Junk bytes before sync are dropped.
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    idle_rx();
    chk("junk_idle", 64'({DEBUG_SIG, busy, error, core_nrst}), 64'b0001);
    wbuf[0] = 32'hDEAD_BEEF;
    do_load(1, 1'b0);

    // Oversized length (1025) errors; a new sync clears it, and N=0 completes directly.
    w0 = we_cnt;
    send(8'hA5, 1'b0);
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    idle_rx();
    chk("len_err_flags", 64'({rx_ready, DEBUG_SIG, core_nrst, busy, error}), 64'b10001);
    chk("len_err_no_we", 64'(we_cnt - w0), 64'd0);
    d0 = done_cnt;
    send(8'hA5, 1'b0);
    idle_rx();
    chk("resync_clears_err", 64'({error, DEBUG_SIG}), 64'b01);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    idle_rx();
    wait_done(d0);
    chk("zero_len_no_we", 64'(we_cnt - w0), 64'd0);
    chk("zero_len_addr", 64'(DEBUG_addr), 64'(BASE));

    // Random gaps must not change the write sequence.
    wbuf[0] = 32'h1234_5678;
    wbuf[1] = 32'h0000_0001;
    wbuf[2] = 32'hFFFF_FFFF;
    do_load(3, 1'b1);
    chk("ready_low_in_write", 64'(ready_bad), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    wa.delete();
    wd.delete();
    send(8'hA5, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h45, 1'b0);
    idle_rx();
    chk("csum_bad_error", 64'({error, core_nrst}), 64'b10);
    chk("csum_bad_wr_count", 64'(wa.size()), 64'd1);
    if (wa.size() > 0) chk("csum_bad_word_kept", 64'(wd[0]), 64'h4433_2211);
`endif

    // Length exactly MAX_WORDS is accepted; reset mid-word abandons the load.
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h04, 1'b0);
    send(8'h11, 1'b0);
    chk("max_len_accepted", 64'({DEBUG_SIG, error}), 64'b10);
    send(8'h22, 1'b0);
    w0 = we_cnt;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    nrst = 1'b0;
    #1;
    chk("midrst_flags", 64'({rx_ready, DEBUG_SIG, core_nrst, busy, debug_we}), 64'd0);
    chk("midrst_instr", 64'(DEBUG_instr), 64'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("midrst_release", 64'({core_nrst, DEBUG_SIG}), 64'b10);
    chk("midrst_no_we", 64'(we_cnt - w0), 64'd0);
    wbuf[0] = 32'h0BAD_F00D;
    do_load(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/debug_loader.md
DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: address of the first loaded word.
REQ-002 Parameter MAX_WORDS, default 1024: largest accepted word count.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port nrst, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port rx_valid, input, 1: a byte is offered on rx_data.
REQ-006 Port rx_data, input, 8: offered byte.
REQ-007 Port rx_ready, output, 1: the loader accepts the byte; transfer occurs when rx_valid and rx_ready are both 1 at a clk edge.
REQ-008 Port DEBUG_SIG, output, 1: load in progress; drives the core's debug-load select.
REQ-009 Port DEBUG_addr, output, 32: byte address of the word being written.
REQ-010 Port DEBUG_instr, output, 32: word being written.
REQ-011 Port debug_we, output, 1: one-cycle write strobe; DEBUG_addr and DEBUG_instr are valid while it is 1.
REQ-012 Port core_nrst, output, 1: active-low reset to the core; held low while a load is active or has failed.
REQ-013 Port busy, output, 1: state is neither IDLE nor ERROR.
REQ-014 Port done, output, 1: one-cycle pulse on successful load completion.
REQ-015 Port error, output, 1: load failed; held while in ERROR.

Function
REQ-016 States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR.
REQ-017 rx_ready is 1 in IDLE, LEN0, LEN1, DATA, CSUM and ERROR, and 0 in WRITE and DONE.
REQ-018 IDLE and ERROR: accepting sync byte 8'hA5 moves to LEN0, sets DEBUG_addr to BASE_ADDR, clears the byte counter and checksum, and clears error; any other accepted byte is discarded.
REQ-019 LEN0/LEN1: accept the low and then the high byte of the 16-bit word count N (little-endian).
REQ-020 On leaving LEN1: if N > MAX_WORDS, go to ERROR; if N = 0, go to DONE; otherwise go to DATA.
REQ-021 DATA: accept 4 bytes little-endian into DEBUG_instr (first byte goes to [7:0]); the cycle after the 4th byte is accepted, go to WRITE.
REQ-022 WRITE lasts exactly 1 cycle with debug_we=1; on exit, DEBUG_addr += 4 (modulo 2^32, wrap permitted) and the remaining-word count decrements.
REQ-023 After the WRITE of word N: go to CSUM if the checksum is compiled in, else go to DONE.
REQ-024 DONE lasts 1 cycle with done=1, then goes to IDLE.
REQ-025 DEBUG_SIG is 1 and core_nrst is 0 in LEN0 through DONE; core_nrst is also 0 in ERROR.
REQ-026 DEBUG_SIG is 0 in IDLE and ERROR; core_nrst is 1 in IDLE.
REQ-027 Throughput: one byte per cycle when rx_valid is held high; N words take 4N+N+3 cycles from sync to done (excluding CSUM).
REQ-028 Stalls (rx_valid=0) hold state and all registers unchanged in every state.
REQ-029 Words already written before an error are not retracted.

Reset
REQ-030 nrst=0 asynchronously forces state IDLE and sets DEBUG_SIG=0, debug_we=0, done=0, error=0, DEBUG_addr=BASE_ADDR, DEBUG_instr=0 and counters=0.
REQ-031 During nrst=0, core_nrst=0 combinationally and rx_ready=0; core_nrst returns to 1 in the first cycle after reset release.
REQ-032 Reset in the middle of a load abandons it; no debug_we is issued after reset asserts.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN defined: a running XOR of all 4N data bytes (sync and length bytes excluded) is kept; CSUM accepts one byte; a match goes to DONE and a mismatch goes to ERROR.
REQ-034 LOADER_CHECKSUM_EN undefined: no checksum register and no CSUM state; the last WRITE goes directly to DONE.

Verification
REQ-035 Stream A5,02,00,13,00,00,00,93,00,10,00 (plus checksum 8'h90 if enabled), rx_valid held high -> debug_we at addr 0 with 32'h00000013, then at addr 4 with 32'h00100093; then done pulse; core_nrst rises.
REQ-036 Bytes 00,FF before A5 in IDLE -> both discarded, no state change; load proceeds normally after A5.
REQ-037 Length field 0x0401 with MAX_WORDS=1024 -> ERROR, error=1, core_nrst=0, no debug_we; a new A5 clears error.
REQ-038 Random rx_valid gaps during a 3-word load -> identical write sequence to gap-free case; rx_ready=0 during each WRITE cycle.
REQ-039 With LOADER_CHECKSUM_EN, 1-word load 11,22,33,44 and checksum 8'h45 -> ERROR (correct value 8'h44), word still written.
REQ-040 nrst pulsed after 2 data bytes -> IDLE, DEBUG_SIG=0, no debug_we; a following full load succeeds from BASE_ADDR.
